// File: rtl/sum_every_n.sv
// rtl/sum_every_n.sv - streaming reducer: sums each group of GROUP accepted beats
// and emits one sum per group, with valid/ready on both sides and early close via i_last.
module sum_every_n #(
    parameter int IW    = 4,
    parameter int GROUP = 3,
    localparam int OW   = (GROUP == 1) ? IW : IW + $clog2(GROUP),
    localparam int CW   = $clog2(GROUP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_dval,
    output logic          i_rdy,
    input  logic          i_last,
    input  logic [IW-1:0] i,
    output logic          o_dval,
    input  logic          o_rdy,
    output logic [OW-1:0] o,
    output logic [CW-1:0] o_cnt
);

    localparam int NW = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [NW-1:0] LAST_CNT = NW'(GROUP - 1);

    logic [NW-1:0] cnt;
    logic [OW-1:0] acc;
    logic          full_beat;
    logic          closing;
    logic          accept;
    logic [OW-1:0] sum;

    assign full_beat = (cnt == LAST_CNT);
    assign closing   = full_beat || i_last;

    // Only a closing beat needs the output register; it may go when the
    // register is empty or being drained in this same cycle.
    assign i_rdy  = !o_dval || o_rdy || !closing;
    assign accept = i_dval && i_rdy;

    // The first beat of a group replaces whatever is left in acc.
    assign sum = (cnt == '0) ? OW'(i) : acc + OW'(i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            o_dval <= 1'b0;
            o      <= '0;
            o_cnt  <= '0;
        end else begin
            if (accept) begin
                if (closing) begin
                    o     <= sum;
                    o_cnt <= CW'(cnt) + CW'(1);
                    cnt   <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + NW'(1);
                end
            end
            if (accept && closing) begin
                o_dval <= 1'b1;
            end else if (o_rdy) begin
                o_dval <= 1'b0;
            end
        end
    end

endmodule
